// File: rtl/delay_slot_tracker.sv
// ============================================================================
// delay_slot_tracker
// ----------------------------------------------------------------------------
// Branch-delay-slot tracker for the exception pipeline.
//
// The D-stage instruction is decoded as a control transfer or not. The next
// valid instruction that advances out of D after a control transfer is marked
// as a delay slot (BD). The BD flag and PC then travel through DEPTH pipeline
// registers. At the commit output, CP0 sees BD and a corrected EPC. When BD is
// set, EPC points back at the branch.
//
// Stall cycles insert bubbles into stage 1. Stages 2..DEPTH always shift.
// Flush clears every stage and drops any pending slot.
//
// Configuration macro:
//   BD_LIKELY_EN - adds the branch-likely opcodes (beql/bnel/blezl/bgtzl).
//                  A not-taken likely nullifies its slot. The slot then
//                  retires as a bubble and never raises BD/EPC.
//                  When the macro is undefined:
//                    - likely opcodes decode as ordinary instructions,
//                    - annul_d is tied low,
//                    - br_taken_d is ignored.
//
// Parameters:
//   PC_W     PC / EPC width in bits
//   DEPTH    registered stages between D and the commit output (1..8)
//   PC_STEP  byte distance subtracted from a delay-slot PC to form EPC
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   instr_d     instruction currently in D
//   pc_d        PC of instr_d
//   valid_d     instr_d is a real instruction (not a bubble)
//   stall       D frozen this cycle; a bubble enters stage 1
//   flush       exception/eret flush: kill all stages and tracking state
//   br_taken_d  D-stage branch outcome (only used with BD_LIKELY_EN)
//   is_br_d     comb: instr_d is a control transfer
//   bd_d        comb: instr_d sits in a delay slot
//   valid_out   stage-DEPTH valid
//   bd_out      stage-DEPTH BD flag
//   pc_out      stage-DEPTH PC
//   epc_out     comb: bd_out ? pc_out - PC_STEP : pc_out (mod 2^PC_W)
//   annul_d     comb: instr_d is a nullified likely slot
// ============================================================================
module delay_slot_tracker #(
    parameter int PC_W    = 32,
    parameter int DEPTH   = 3,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_d,
    input  logic [PC_W-1:0] pc_d,
    input  logic            valid_d,
    input  logic            stall,
    input  logic            flush,
    input  logic            br_taken_d,
    output logic            is_br_d,
    output logic            bd_d,
    output logic            valid_out,
    output logic            bd_out,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] epc_out,
    output logic            annul_d
);

    // ------------------------------------------------------------------------
    // Opcode / field encodings
    // ------------------------------------------------------------------------
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
`ifdef BD_LIKELY_EN
    localparam logic [5:0] OP_BEQL    = 6'b010100;
    localparam logic [5:0] OP_BNEL    = 6'b010101;
    localparam logic [5:0] OP_BLEZL   = 6'b010110;
    localparam logic [5:0] OP_BGTZL   = 6'b010111;
`endif

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // ------------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_NORM  = 2'd0;
    localparam logic [1:0] S_SLOT  = 2'd1;
    localparam logic [1:0] S_ANNUL = 2'd2;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    // ------------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] funct;

    assign opcode = instr_d[31:26];
    assign rt     = instr_d[20:16];
    assign funct  = instr_d[5:0];

    // Register/immediate fields play no part in branch classification.
    logic unused_bits;
`ifdef BD_LIKELY_EN
    assign unused_bits = ^{instr_d[25:21], instr_d[15:6]};
`else
    assign unused_bits = ^{instr_d[25:21], instr_d[15:6], br_taken_d};
`endif

    // ------------------------------------------------------------------------
    // Control-transfer decode
    // ------------------------------------------------------------------------
    logic is_likely;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        is_br_d   = 1'b0;
        is_likely = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: is_br_d = 1'b1;
            OP_REGIMM:  is_br_d = (rt == RT_BLTZ) || (rt == RT_BGEZ);
            OP_SPECIAL: is_br_d = (funct == FN_JR) || (funct == FN_JALR);
`ifdef BD_LIKELY_EN
            OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL: begin
                is_br_d   = 1'b1;
                is_likely = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Slot-tracking FSM
    // ------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_next;
    logic       advance;
    logic [1:0] after_branch;

    // D hands its instruction to stage 1 only when it is real and not held.
    assign advance = valid_d & ~stall & ~flush;

    // Target state when the advancing instruction is a control transfer.
    // A not-taken likely nullifies its slot instead of executing it.
`ifdef BD_LIKELY_EN
    assign after_branch = (is_likely && !br_taken_d) ? S_ANNUL : S_SLOT;
`else
    assign after_branch = S_SLOT;
    logic unused_likely;
    assign unused_likely = is_likely;
`endif

    assign bd_d = valid_d & (state != S_NORM);

`ifdef BD_LIKELY_EN
    assign annul_d = valid_d & (state == S_ANNUL);
`else
    assign annul_d = 1'b0;
`endif

    always_comb begin
        state_next = state;
        if (flush) begin
            // A branch flushed from D leaves no pending slot.
            state_next = S_NORM;
        end else if (advance) begin
            case (state)
                S_NORM:  state_next = is_br_d ? after_branch : S_NORM;
                // A branch sitting in a slot arms a fresh slot of its own.
                S_SLOT:  state_next = is_br_d ? after_branch : S_NORM;
                // The nullified instruction never executes, so it cannot arm a slot.
                S_ANNUL: state_next = S_NORM;
                default: state_next = S_NORM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // that every register samples pre-edge values regardless of order.
        if (reset) begin
            state <= S_NORM;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // BD / PC pipeline, stages 1..DEPTH (index 0 is stage 1)
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] bd_q;
    logic [PC_W-1:0]  pc_q [DEPTH];

    logic             keep_d;

    // An annulled slot enters the pipe as a bubble that never raises BD.
    assign keep_d = ~annul_d;

    always_ff @(posedge clk) begin
        // NOTE: the stage array is small and its contents reach an output,
        // so it is cleared on reset and flush rather than left undefined.
        if (reset || flush) begin
            v_q  <= '0;
            bd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            // Stage 1 takes a bubble while D is stalled.
            if (stall) begin
                v_q[0]  <= 1'b0;
                bd_q[0] <= 1'b0;
                pc_q[0] <= '0;
            end else begin
                v_q[0]  <= valid_d & keep_d;
                bd_q[0] <= bd_d & keep_d;
                pc_q[0] <= pc_d;
            end

            // Downstream stages keep moving while D is stalled.
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i]  <= v_q[i-1];
                bd_q[i] <= bd_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Commit outputs
    // ------------------------------------------------------------------------
    assign valid_out = v_q[DEPTH-1];
    assign bd_out    = bd_q[DEPTH-1];
    assign pc_out    = pc_q[DEPTH-1];

    // A delay-slot exception restarts at the branch, one instruction back.
    assign epc_out   = bd_out ? (pc_out - STEP) : pc_out;

endmodule

// File: tb/tb_delay_slot_tracker.sv
// Directed bench for delay_slot_tracker with DEPTH=3 and PC_W=32.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled at that same point, away from the edge.
module tb_delay_slot_tracker;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     instr_d;
    logic [PC_W-1:0] pc_d;
    logic            valid_d;
    logic            stall;
    logic            flush;
    logic            br_taken_d;
    logic            is_br_d;
    logic            bd_d;
    logic            valid_out;
    logic            bd_out;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] epc_out;
    logic            annul_d;

    int n_vec = 0;
    int n_err = 0;

    // Instruction encodings (register fields zero)
    localparam logic [31:0] I_BEQ   = 32'h1000_0000;
    localparam logic [31:0] I_BNE   = 32'h1400_0000;
    localparam logic [31:0] I_BGTZ  = 32'h1C00_0000;
    localparam logic [31:0] I_J     = 32'h0800_0000;
    localparam logic [31:0] I_JAL   = 32'h0C00_0000;
    localparam logic [31:0] I_BLTZ  = 32'h0400_0000;
    localparam logic [31:0] I_BGEZ  = 32'h0401_0000;
    localparam logic [31:0] I_RIMM2 = 32'h0402_0000;
    localparam logic [31:0] I_JR    = 32'h0000_0008;
    localparam logic [31:0] I_JALR  = 32'h0000_0009;
    localparam logic [31:0] I_ADDU  = 32'h0000_0021;
    localparam logic [31:0] I_OR    = 32'h0000_0025;
    localparam logic [31:0] I_LW    = 32'h8C00_0000;
    localparam logic [31:0] I_SW    = 32'hAC00_0000;
    localparam logic [31:0] I_BEQL  = 32'h5000_0000;

    delay_slot_tracker #(.PC_W(PC_W), .DEPTH(3), .PC_STEP(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .valid_d    (valid_d),
        .stall      (stall),
        .flush      (flush),
        .br_taken_d (br_taken_d),
        .is_br_d    (is_br_d),
        .bd_d       (bd_d),
        .valid_out  (valid_out),
        .bd_out     (bd_out),
        .pc_out     (pc_out),
        .epc_out    (epc_out),
        .annul_d    (annul_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                         input logic st, input logic fl, input logic tk);
        instr_d    = ins;
        pc_d       = pc;
        valid_d    = v;
        stall      = st;
        flush      = fl;
        br_taken_d = tk;
        #0;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic v, input logic bd,
                             input logic [31:0] pc, input logic [31:0] epc);
        check({tag, ".v"},   {31'b0, valid_out}, {31'b0, v});
        check({tag, ".bd"},  {31'b0, bd_out},    {31'b0, bd});
        check({tag, ".pc"},  pc_out,  pc);
        check({tag, ".epc"}, epc_out, epc);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();

        // 1: reset state
        check_out("reset", 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

        // Decode table
        drive(I_BLTZ, 0, 1, 0, 0, 0);  #1; check("dec.bltz",  {31'b0, is_br_d}, 32'd1);
        drive(I_BGEZ, 0, 1, 0, 0, 0);  #1; check("dec.bgez",  {31'b0, is_br_d}, 32'd1);
        drive(I_RIMM2, 0, 1, 0, 0, 0); #1; check("dec.rimm2", {31'b0, is_br_d}, 32'd0);
        drive(I_JALR, 0, 1, 0, 0, 0);  #1; check("dec.jalr",  {31'b0, is_br_d}, 32'd1);
        drive(I_ADDU, 0, 1, 0, 0, 0);  #1; check("dec.addu",  {31'b0, is_br_d}, 32'd0);
        drive(I_BGTZ, 0, 1, 0, 0, 0);  #1; check("dec.bgtz",  {31'b0, is_br_d}, 32'd1);
        // Nothing above advanced: no clock edge has occurred since reset.
        check("dec.bd", {31'b0, bd_d}, 32'd0);

        // 2: beq@0x100, addu@0x104
        drive(I_BEQ, 32'h100, 1, 0, 0, 0); #1;
        check("t2.beq_bd_d", {31'b0, bd_d}, 32'd0);
        tick();
        drive(I_ADDU, 32'h104, 1, 0, 0, 0); #1;
        check("t2.slot_bd_d", {31'b0, bd_d}, 32'd1);
        tick();
        idle();
        tick();
        check_out("t2.beq", 1'b1, 1'b0, 32'h100, 32'h100);
        tick();
        check_out("t2.slot", 1'b1, 1'b1, 32'h104, 32'h100);
        tick();
        check("t2.after_bd_d", {31'b0, bd_d}, 32'd0);

        // 3: jal@0x200, two stall cycles, then or@0x204
        drive(I_JAL, 32'h200, 1, 0, 0, 0);
        tick();
        drive(I_OR, 32'h204, 1, 1, 0, 0); #1;
        check("t3.stall_bd_d", {31'b0, bd_d}, 32'd1);
        tick();
        tick();
        check_out("t3.jal", 1'b1, 1'b0, 32'h200, 32'h200);
        drive(I_OR, 32'h204, 1, 0, 0, 0); #1;
        check("t3.held_bd_d", {31'b0, bd_d}, 32'd1);
        tick();
        idle();
        check_out("t3.bub1", 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_out("t3.bub2", 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_out("t3.or", 1'b1, 1'b1, 32'h204, 32'h200);

        // 4: jr@0x300, flush arrives with the slot
        drive(I_JR, 32'h300, 1, 0, 0, 0);
        tick();
        drive(I_ADDU, 32'h304, 1, 0, 1, 0);
        tick();
        check_out("t4.flush0", 1'b0, 1'b0, 32'h0, 32'h0);
        drive(I_LW, 32'h400, 1, 0, 0, 0); #1;
        check("t4.lw_bd_d", {31'b0, bd_d}, 32'd0);
        tick();
        idle();
        check("t4.flush1.v", {31'b0, valid_out}, 32'd0);
        tick();
        check("t4.flush2.v", {31'b0, valid_out}, 32'd0);
        tick();
        check_out("t4.lw", 1'b1, 1'b0, 32'h400, 32'h400);

        // Flush wins over stall: a pending slot is dropped.
        drive(I_BNE, 32'h700, 1, 0, 0, 0);
        tick();
        drive(I_ADDU, 32'h704, 1, 1, 1, 0);
        tick();
        drive(I_ADDU, 32'h708, 1, 0, 0, 0); #1;
        check("t4b.bd_d", {31'b0, bd_d}, 32'd0);
        tick();
        idle();

        // Back-to-back branches: beq@0x600, bne@0x604, addu@0x608, or@0x60C
        drive(I_BEQ, 32'h600, 1, 0, 0, 0);
        tick();
        drive(I_BNE, 32'h604, 1, 0, 0, 0); #1;
        check("bb.bne_bd_d", {31'b0, bd_d}, 32'd1);
        tick();
        drive(I_ADDU, 32'h608, 1, 0, 0, 0); #1;
        check("bb.addu_bd_d", {31'b0, bd_d}, 32'd1);
        tick();
        drive(I_OR, 32'h60C, 1, 0, 0, 0); #1;
        check("bb.or_bd_d", {31'b0, bd_d}, 32'd0);
        check_out("bb.beq", 1'b1, 1'b0, 32'h600, 32'h600);
        tick();
        idle();
        check_out("bb.bne", 1'b1, 1'b1, 32'h604, 32'h600);
        tick();
        check_out("bb.addu", 1'b1, 1'b1, 32'h608, 32'h604);
        tick();
        check_out("bb.or", 1'b1, 1'b0, 32'h60C, 32'h60C);

        // 5: EPC wrap: j@0xFFFF_FFFC, slot@0x0
        drive(I_J, 32'hFFFF_FFFC, 1, 0, 0, 0);
        tick();
        drive(I_ADDU, 32'h0, 1, 0, 0, 0);
        tick();
        idle();
        tick();
        check_out("t5.j", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        tick();
        check_out("t5.wrap", 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);

`ifdef BD_LIKELY_EN
        // 6a: beql not taken -> slot annulled
        drive(I_BEQL, 32'h500, 1, 0, 0, 0); #1;
        check("t6a.is_br", {31'b0, is_br_d}, 32'd1);
        tick();
        drive(I_SW, 32'h504, 1, 0, 0, 0); #1;
        check("t6a.annul_d", {31'b0, annul_d}, 32'd1);
        check("t6a.bd_d", {31'b0, bd_d}, 32'd1);
        tick();
        drive(I_ADDU, 32'h508, 1, 0, 0, 0); #1;
        check("t6a.next_bd_d", {31'b0, bd_d}, 32'd0);
        check("t6a.next_annul", {31'b0, annul_d}, 32'd0);
        tick();
        idle();
        check_out("t6a.beql", 1'b1, 1'b0, 32'h500, 32'h500);
        tick();
        check("t6a.slot.v", {31'b0, valid_out}, 32'd0);
        check("t6a.slot.bd", {31'b0, bd_out}, 32'd0);
        tick();
        check_out("t6a.addu", 1'b1, 1'b0, 32'h508, 32'h508);

        // 6b: beql taken -> slot retires with BD
        drive(I_BEQL, 32'h500, 1, 0, 0, 1);
        tick();
        drive(I_SW, 32'h504, 1, 0, 0, 0); #1;
        check("t6b.annul_d", {31'b0, annul_d}, 32'd0);
        tick();
        idle();
        tick();
        check_out("t6b.beql", 1'b1, 1'b0, 32'h500, 32'h500);
        tick();
        check_out("t6b.sw", 1'b1, 1'b1, 32'h504, 32'h500);
`else
        // Without likely support beql is an ordinary instruction.
        drive(I_BEQL, 32'h500, 1, 0, 0, 0); #1;
        check("t6.is_br", {31'b0, is_br_d}, 32'd0);
        tick();
        drive(I_SW, 32'h504, 1, 0, 0, 0); #1;
        check("t6.bd_d", {31'b0, bd_d}, 32'd0);
        check("t6.annul_d", {31'b0, annul_d}, 32'd0);
        tick();
        idle();
        tick();
        tick();
        check_out("t6.sw", 1'b1, 1'b0, 32'h504, 32'h504);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
